// File: rtl/cisr_row_decoder_if.sv
// cisr_row_decoder_if: row-length FIFO, element and status signals between the CISR decoder and its channels
interface cisr_row_decoder_if #(
  parameter int NUM_CH = 16,
  parameter int DIM_W = 10,
  parameter int LEN_W = 32
);
  logic spmv_init;
  logic [DIM_W:0] num_rows;
  logic [NUM_CH-1:0] len_valid;
  logic [NUM_CH*LEN_W-1:0] len_in;
  logic [NUM_CH-1:0] pop_len;
  logic [NUM_CH-1:0] elem_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH*DIM_W-1:0] row_id_out;
  logic dec_done;
  logic dec_err;
  modport master (
    output spmv_init, num_rows, len_valid, len_in, elem_valid,
    input pop_len, ch_ready, row_id_out, dec_done, dec_err
  );
  modport slave (
    input spmv_init, num_rows, len_valid, len_in, elem_valid,
    output pop_len, ch_ready, row_id_out, dec_done, dec_err
  );
endinterface

// File: rtl/cisr_row_decoder.sv
// cisr_row_decoder: assigns global row IDs to channels lowest-first and counts down row nonzeros; CISR_DEC_ERR_EN enables sticky dec_err
module cisr_row_decoder #(
  parameter int NUM_CH = 16,
  parameter int DIM_W = 10,
  parameter int LEN_W = 32
) (
  input logic clk,
  input logic rst_n,
  cisr_row_decoder_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} st_t;
  localparam int CW = DIM_W + 2;
  st_t st_q [NUM_CH];
  st_t st_d [NUM_CH];
  logic [LEN_W-1:0] rem_q [NUM_CH];
  logic [LEN_W-1:0] rem_d [NUM_CH];
  logic [DIM_W-1:0] rid_q [NUM_CH];
  logic [DIM_W-1:0] rid_d [NUM_CH];
  logic [DIM_W:0] rows_total_q, next_row_q, next_row_d;
  logic dec_done_q, dec_done_d;
  logic [NUM_CH-1:0] req, grant, idle;
  logic [CW-1:0] id;
  logic clr;
  assign clr = !rst_n || bus.spmv_init;
  always_ff @(posedge clk) begin
    if (!rst_n) rows_total_q <= '0;
    else if (bus.spmv_init) rows_total_q <= bus.num_rows;
    next_row_q <= clr ? '0 : next_row_d;
    dec_done_q <= clr ? 1'b0 : dec_done_d;
    for (int c = 0; c < NUM_CH; c++) begin
      st_q[c] <= clr ? IDLE : st_d[c];
      rem_q[c] <= clr ? '0 : rem_d[c];
      rid_q[c] <= clr ? '0 : rid_d[c];
    end
  end
  // id walks up from next_row as each requester in ascending order is granted
  always_comb begin
    id = CW'(next_row_q);
    for (int c = 0; c < NUM_CH; c++) begin
      idle[c] = st_q[c] == IDLE;
      req[c] = (idle[c] || (rem_q[c] == LEN_W'(1) && bus.elem_valid[c])) && bus.len_valid[c] && next_row_q < rows_total_q;
      grant[c] = req[c] && id < CW'(rows_total_q);
      st_d[c] = st_q[c];
      rem_d[c] = rem_q[c];
      rid_d[c] = rid_q[c];
      if (grant[c]) begin
        rid_d[c] = id[DIM_W-1:0];
        rem_d[c] = bus.len_in[c*LEN_W +: LEN_W];
        st_d[c] = rem_d[c] == '0 ? IDLE : ACTIVE;
        id = id + CW'(1);
      end else if (!idle[c] && bus.elem_valid[c]) begin
        rem_d[c] = rem_q[c] - LEN_W'(1);
        st_d[c] = rem_d[c] == '0 ? IDLE : ACTIVE;
      end
    end
    next_row_d = id[DIM_W:0];
    dec_done_d = dec_done_q || (next_row_q == rows_total_q && &idle && grant == '0);
  end
  assign bus.pop_len = grant;
  assign bus.ch_ready = ~idle;
  assign bus.dec_done = dec_done_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_rid
    assign bus.row_id_out[g*DIM_W +: DIM_W] = rid_q[g];
  end
`ifdef CISR_DEC_ERR_EN
  logic dec_err_q;
  always_ff @(posedge clk) begin
    dec_err_q <= clr ? 1'b0 : dec_err_q || |(idle & (bus.elem_valid | (bus.len_valid & {NUM_CH{next_row_q == rows_total_q}})));
  end
  assign bus.dec_err = dec_err_q;
`else
  assign bus.dec_err = 1'b0;
`endif
endmodule

// File: tb/tb_cisr_row_decoder.sv
// tb_cisr_row_decoder: directed vector table, dec_err sequence and randomized runs against a row-assignment model
module tb_cisr_row_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cisr_row_decoder_if #(.NUM_CH(4), .DIM_W(10), .LEN_W(32)) bus ();
  cisr_row_decoder #(.NUM_CH(4), .DIM_W(10), .LEN_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic init;
    logic [10:0] nr;
    logic [3:0] lv;
    logic [127:0] len;
    logic [3:0] ev;
    logic [3:0] pop;
    logic [3:0] rdy;
    logic [39:0] rid;
    logic done;
  } vec_t;
  function automatic logic [127:0] lp(int a, int b, int c, int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction
  function automatic logic [39:0] rp(int a, int b, int c, int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction
  function automatic vec_t mk(logic i, int n, logic [3:0] lv, logic [127:0] len, logic [3:0] ev,
                              logic [3:0] pop, logic [3:0] rdy, logic [39:0] rid, logic d);
    vec_t v;
    v.init = i; v.nr = 11'(n); v.lv = lv; v.len = len; v.ev = ev;
    v.pop = pop; v.rdy = rdy; v.rid = rid; v.done = d;
    return v;
  endfunction
  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  vec_t vt [$];
  int q [4][$];
  int m_rem [4];
  int m_rid [4];
  int m_id [4];
  int m_next, m_total, nr;
  bit m_done, nd, seen, all_idle;
  logic [3:0] gnt, lv, ev, exp_rdy;
  logic [127:0] len;
  logic [39:0] exp_rid;
  initial begin
    // four channels loaded in one cycle
    vt.push_back(mk(1, 4, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b1111, lp(2,1,3,1), 4'b0000, 4'b1111, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b1111, 4'b0000, 4'b1111, rp(0,1,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0101, 4'b0000, 4'b0101, rp(0,1,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0100, 4'b0000, 4'b0100, rp(0,1,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(0,1,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(0,1,2,3), 1));
    // back-to-back rows on channel 0
    vt.push_back(mk(1, 2, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(0,1,2,3), 1));
    vt.push_back(mk(0, 0, 4'b0001, lp(2,0,0,0), 4'b0001, 4'b0001, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0001, lp(3,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0001, lp(3,0,0,0), 4'b0001, 4'b0001, 4'b0001, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(1,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(1,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(1,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(1,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(1,0,0,0), 1));
    // zero-length rows
    vt.push_back(mk(1, 3, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(1,0,0,0), 1));
    vt.push_back(mk(0, 0, 4'b0001, lp(0,0,0,0), 4'b0000, 4'b0001, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0001, lp(0,0,0,0), 4'b0000, 4'b0001, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0001, lp(2,0,0,0), 4'b0000, 4'b0001, 4'b0000, rp(1,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(2,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(2,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0001, lp(5,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(2,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(2,0,0,0), 1));
    // contention for the last row
    vt.push_back(mk(1, 6, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(2,0,0,0), 1));
    vt.push_back(mk(0, 0, 4'b1111, lp(0,2,0,2), 4'b0000, 4'b1111, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0001, lp(0,0,0,0), 4'b1010, 4'b0001, 4'b1010, rp(0,1,2,3), 0));
    vt.push_back(mk(0, 0, 4'b1010, lp(0,1,0,1), 4'b1010, 4'b0010, 4'b1010, rp(4,1,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0010, 4'b0000, 4'b0010, rp(4,5,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(4,5,2,3), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(4,5,2,3), 1));
    // abort mid-row, then a fresh two-row run
    vt.push_back(mk(1, 4, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(4,5,2,3), 1));
    vt.push_back(mk(0, 0, 4'b0001, lp(4,0,0,0), 4'b0000, 4'b0001, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(0,0,0,0), 0));
    vt.push_back(mk(1, 2, 4'b0000, lp(0,0,0,0), 4'b0001, 4'b0000, 4'b0001, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0011, lp(1,1,0,0), 4'b0000, 4'b0011, 4'b0000, rp(0,0,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0011, 4'b0000, 4'b0011, rp(0,1,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(0,1,0,0), 0));
    vt.push_back(mk(0, 0, 4'b0000, lp(0,0,0,0), 4'b0000, 4'b0000, 4'b0000, rp(0,1,0,0), 1));
    bus.spmv_init = 1'b0; bus.num_rows = '0; bus.len_valid = '0; bus.len_in = '0; bus.elem_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop", bus.pop_len, 4'b0000);
    check("rst_rdy", bus.ch_ready, 4'b0000);
    check("rst_rid", bus.row_id_out, 40'd0);
    check("rst_done", bus.dec_done, 1'b0);
    check("rst_err", bus.dec_err, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      bus.spmv_init = vt[i].init; bus.num_rows = vt[i].nr; bus.len_valid = vt[i].lv;
      bus.len_in = vt[i].len; bus.elem_valid = vt[i].ev;
      #4;
      check($sformatf("v%0d_pop", i), bus.pop_len, vt[i].pop);
      check($sformatf("v%0d_rdy", i), bus.ch_ready, vt[i].rdy);
      check($sformatf("v%0d_rid", i), bus.row_id_out, vt[i].rid);
      check($sformatf("v%0d_done", i), bus.dec_done, vt[i].done);
      @(posedge clk);
      #1;
    end
    // elem_valid on an idle channel
    bus.spmv_init = 1'b1; bus.num_rows = 11'd3; bus.len_valid = '0; bus.elem_valid = '0;
    @(posedge clk);
    #1;
    bus.spmv_init = 1'b0;
    #3;
    check("err_clear", bus.dec_err, 1'b0);
    bus.elem_valid = 4'b0001;
    @(posedge clk);
    #1;
    bus.elem_valid = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      #3;
`ifdef CISR_DEC_ERR_EN
      check("err_sticky", bus.dec_err, 1'b1);
`else
      check("err_tied", bus.dec_err, 1'b0);
`endif
      check("err_rdy", bus.ch_ready, 4'b0000);
      @(posedge clk);
      #1;
    end
    // randomized runs against the row-assignment model
    for (int r = 0; r < 8; r++) begin
      m_total = $urandom_range(1, 24);
      for (int c = 0; c < 4; c++) begin
        q[c].delete();
        for (int j = 0; j < 8; j++) q[c].push_back($urandom_range(0, 9) < 2 ? 0 : $urandom_range(1, 4));
      end
      bus.spmv_init = 1'b1; bus.num_rows = 11'(m_total); bus.len_valid = '0; bus.elem_valid = '0;
      @(posedge clk);
      #1;
      bus.spmv_init = 1'b0;
      m_next = 0; m_done = 0; seen = 0;
      for (int c = 0; c < 4; c++) begin m_rem[c] = 0; m_rid[c] = 0; end
      for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
        for (int c = 0; c < 4; c++) begin
          lv[c] = q[c].size() > 0;
          len[c*32 +: 32] = lv[c] ? 32'(q[c][0]) : 32'd0;
          ev[c] = $urandom_range(0, 3) != 0;
        end
        bus.len_valid = lv; bus.len_in = len; bus.elem_valid = ev;
        gnt = '0; nr = m_next;
        for (int c = 0; c < 4; c++) begin
          if ((m_rem[c] == 0 || (m_rem[c] == 1 && ev[c])) && lv[c] && nr < m_total) begin
            gnt[c] = 1'b1; m_id[c] = nr; nr++;
          end
          exp_rdy[c] = m_rem[c] != 0;
          exp_rid[c*10 +: 10] = 10'(m_rid[c]);
        end
        #3;
        check($sformatf("r%0d_pop", r), bus.pop_len, gnt);
        check($sformatf("r%0d_rdy", r), bus.ch_ready, exp_rdy);
        check($sformatf("r%0d_rid", r), bus.row_id_out, exp_rid);
        check($sformatf("r%0d_done", r), bus.dec_done, m_done);
        seen = m_done;
        @(posedge clk);
        #1;
        all_idle = 1;
        for (int c = 0; c < 4; c++) if (m_rem[c] != 0) all_idle = 0;
        nd = m_done || (m_next == m_total && all_idle && gnt == '0);
        for (int c = 0; c < 4; c++) begin
          if (gnt[c]) begin
            m_rid[c] = m_id[c]; m_rem[c] = q[c][0]; void'(q[c].pop_front());
          end else if (m_rem[c] > 0 && ev[c]) m_rem[c]--;
        end
        m_next = nr; m_done = nd;
      end
      check($sformatf("r%0d_finished", r), bus.dec_done, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cisr_row_decoder.md
Name: cisr_row_decoder

Overview:
- Channel-interleaved sparse row (CISR) decoder that sits upstream of the per-channel SpMV multiply pipelines.
- Pops row lengths from each channel's row-length FIFO and assigns global row IDs to channels from one shared next-row counter, lowest channel first.
- Counts down each channel's nonzeros and presents, per channel, the row ID of the element currently in that channel's fetch stage.
- Signals completion once all rows are assigned and every channel has drained.

Parameters:
- NUM_CH, 16, number of channels.
- DIM_W, 10, row-ID width (max 1024 rows).
- LEN_W, 32, row-length word width; matches the channel data width.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- spmv_init  input  1  start pulse; synchronous clear equivalent to reset
- num_rows  input  DIM_W+1  total matrix rows; sampled on spmv_init
- len_valid  input  NUM_CH  per channel: row-length FIFO non-empty
- len_in  input  NUM_CH*LEN_W  per channel: FIFO head row length; channel c at bits [c*LEN_W +: LEN_W]
- pop_len  output  NUM_CH  per channel: pop FIFO head this cycle
- elem_valid  input  NUM_CH  per channel: non-bubble element consumed this cycle
- ch_ready  output  NUM_CH  per channel: active row loaded, elements accepted
- row_id_out  output  NUM_CH*DIM_W  per channel: row ID for the current element
- dec_done  output  1  all rows assigned and all channels idle
- dec_err  output  1  sticky protocol error (optional feature)

Behaviour:
- Reset (rst_n=0 or spmv_init=1 at clk edge): all channels IDLE, remaining=0, row_id=0, next_row=0, dec_done=0, dec_err=0, pop_len=0.
- num_rows is latched into rows_total on the spmv_init cycle.
- Per-channel states:
  - IDLE: no active row; ch_ready=0.
  - ACTIVE: remaining>0; ch_ready=1.
- Request, per channel, is asserted when all of the following hold:
  - the channel is IDLE, or it is ACTIVE with remaining==1 and elem_valid (last element of its row);
  - len_valid=1;
  - next_row < rows_total.
- Grant arbitration:
  - Requests are granted in ascending channel index. The channel of rank k among this cycle's requesters gets row ID next_row+k.
  - Only requesters with next_row+k < rows_total are granted. next_row advances by the number granted.
- pop_len[c] = grant[c], combinational in the same cycle. The FIFO head is loaded next edge: row_id <= assigned ID, remaining <= len_in.
- Back-to-back rows: a last-element cycle plus a grant switches rows with no idle cycle. The element completing the old row still uses the old row_id.
- ACTIVE with elem_valid and remaining>1: remaining decrements by 1.
- ACTIVE with remaining==1, elem_valid and no grant: channel goes IDLE next edge.
- Zero-length row: the ID is consumed and the FIFO popped, then the channel stays IDLE. It may request again next cycle, so at most one empty row per channel per cycle. No element is emitted for it.
- Row-length width: remaining is LEN_W bits. Lengths are not range-checked against matrix size.
- row_id_out is registered and held when IDLE; its value is meaningful only while ch_ready=1.
- elem_valid on an IDLE channel: ignored and no state change.
- dec_done is a registered output. It is set when next_row==rows_total and all channels are IDLE and no grant is pending; it holds until reset or spmv_init.
- num_rows=0 gives dec_done=1 one cycle after the spmv_init cycle.
- spmv_init mid-operation: aborts immediately. All state clears and in-flight rows are dropped.

Optional Feature:
- Macro: CISR_DEC_ERR_EN.
- Defined: dec_err is set sticky on either of these:
  - elem_valid while the channel is IDLE;
  - len_valid while next_row==rows_total and the channel is IDLE (FIFO holds more rows than the matrix).
- dec_err clears only on reset or spmv_init.
- Undefined: dec_err tied to 0; no check logic is synthesized.

Test Plan:
- NUM_CH=4, num_rows=4, lengths {2,1,3,1}, all len_valid on the same cycle -> channels 0..3 get IDs 0..3 in one cycle with pop_len=4'b1111, next_row=4, dec_done after all 7 elements are consumed.
- Single channel, lengths {2,3} queued, continuous elem_valid -> row_id sequence 0,0,1,1,1 with no ch_ready gap; pop_len pulses on cycle 0 and on the last element of row 0.
- Zero-length rows: channel 0 lengths {0,0,2} -> IDs 0 and 1 consumed with no elements, then 2 elements tagged row 2, next_row=3.
- Contention: channels 1 and 3 both finish rows on the same cycle with next_row=5 and rows_total=6 -> channel 1 gets 5, channel 3 gets no grant and goes IDLE, dec_done once both drain.
- spmv_init asserted mid-row (remaining=3) -> next cycle all ch_ready=0, next_row=0, dec_done=0; a new run with num_rows=2 completes normally.
- With CISR_DEC_ERR_EN: elem_valid on an IDLE channel -> dec_err=1 and held; without the macro dec_err stays 0.
